// File: rtl/reg_checker_if.sv
// rtl/reg_checker_if.sv - stimulus/observation bundle between a register under check and reg_checker
interface reg_checker_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic            stop;
    logic            enable;
    logic [SIZE-1:0] d;
    logic [SIZE-1:0] z;
    logic [SIZE-1:0] expect_value;
    logic [15:0]     pass_cnt;
    logic [15:0]     fail_cnt;
    logic            error;
    logic            busy;
    logic            done;

    modport master (
        output start, stop, enable, d, z,
        input  expect_value, pass_cnt, fail_cnt, error, busy, done
    );

    modport slave (
        input  start, stop, enable, d, z,
        output expect_value, pass_cnt, fail_cnt, error, busy, done
    );
endinterface

// File: rtl/reg_checker.sv
// rtl/reg_checker.sv - golden-model checker comparing a register's output against its write history
// Optional CHK_HALT_ON_FAIL_EN: first mismatch in a run moves the checker to FAIL and stops comparing.
module reg_checker #(
    parameter int SIZE = 32
) (
    input  logic           clk,
    input  logic           reset,
    reg_checker_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    state_t          state;
    state_t          state_next;
    logic [SIZE-1:0] expect_q;
    logic [15:0]     pass_q;
    logic [15:0]     fail_q;
    logic            error_q;
    logic            model_valid;
    logic            compare;
    logic            match;
    logic            halt;
    logic            busy_c;
    logic            done_c;

    // z is compared against the pre-edge model, i.e. the value the register should hold now
    assign compare = (state == RUN) && model_valid;
    assign match   = (bus.z == expect_q);

`ifdef CHK_HALT_ON_FAIL_EN
    assign halt = compare && !match;
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, FAIL: if (bus.start) state_next = RUN;
            RUN: begin
                if (bus.stop) begin
                    state_next = DONE;
                end else if (halt) begin
                    state_next = FAIL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == RUN);
        done_c = (state == DONE) || (state == FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            expect_q    <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            error_q     <= 1'b0;
            model_valid <= 1'b0;
        end else if (state != RUN) begin
            if (state_next == RUN) begin
                pass_q      <= '0;
                fail_q      <= '0;
                error_q     <= 1'b0;
                model_valid <= 1'b0;
            end
        end else begin
            if (compare) begin
                if (match) begin
                    pass_q <= (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
                end else begin
                    fail_q  <= (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;
                    error_q <= 1'b1;
                end
            end
            if (bus.enable) begin
                expect_q    <= bus.d;
                model_valid <= 1'b1;
            end
        end
    end

    assign bus.expect_value = expect_q;
    assign bus.pass_cnt     = pass_q;
    assign bus.fail_cnt     = fail_q;
    assign bus.error        = error_q;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
endmodule

// File: tb/tb_reg_checker.sv
// tb/tb_reg_checker.sv - randomized self-checking bench for reg_checker with a behavioural model
module tb_reg_checker;
`ifdef CHK_HALT_ON_FAIL_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    typedef enum {P_IDLE, P_RUN, P_DONE, P_FAIL} phase_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_checker_if #(.SIZE(32)) ifc ();
    reg_checker #(.SIZE(32)) dut (.clk(clk), .reset(reset), .bus(ifc));

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] reg_q  = '0;

    phase_t      m_phase;
    logic [31:0] m_exp;
    int          m_pass;
    int          m_fail;
    bit          m_err;
    bit          m_valid;

    logic [66:0] obs_v;
    logic [66:0] exp_v;

    task automatic model_edge();
        bit halt_now;
        halt_now = 1'b0;
        if (reset) begin
            m_phase = P_IDLE; m_exp = '0; m_pass = 0; m_fail = 0; m_err = 0; m_valid = 0;
            return;
        end
        if (m_phase != P_RUN) begin
            if (ifc.start) begin
                m_phase = P_RUN; m_pass = 0; m_fail = 0; m_err = 0; m_valid = 0;
            end
        end else begin
            if (m_valid) begin
                if (ifc.z == m_exp) begin
                    if (m_pass < 65535) m_pass++;
                end else begin
                    if (m_fail < 65535) m_fail++;
                    m_err    = 1'b1;
                    halt_now = HALT;
                end
            end
            if (ifc.enable) begin
                m_exp   = ifc.d;
                m_valid = 1'b1;
            end
            if (ifc.stop)       m_phase = P_DONE;
            else if (halt_now)  m_phase = P_FAIL;
        end
    endtask

    // one clock: model sees the pre-edge inputs, the register under check updates, pulses drop
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (ifc.enable) reg_q = ifc.d;
        ifc.z     = reg_q;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        obs_v = {ifc.expect_value, ifc.pass_cnt, ifc.fail_cnt, ifc.error, ifc.busy, ifc.done};
        exp_v = {m_exp, 16'(m_pass), 16'(m_fail), m_err, m_phase == P_RUN,
                 (m_phase == P_DONE) || (m_phase == P_FAIL)};
    endtask

    task automatic do_reset();
        reset = 1'b1; ifc.enable = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifc.start = 1'b1; ifc.enable = 1'b1; ifc.d = $urandom; ifc.z = 'x;
            tick();
        end
        checks++;
        if (obs_v !== 67'd0) begin
            fails++; $display("FAIL reset_outputs got %h want %h", obs_v, 67'd0);
        end
        reset = 1'b0; ifc.enable = 1'b0; ifc.z = reg_q;
    endtask

    task automatic test_random_run();
        ifc.start = 1'b1; tick();
        for (int k = 1; k <= 20; k++) begin
            ifc.enable = 1'b1; ifc.d = $urandom; ifc.stop = (k == 20);
            tick();
        end
        ifc.enable = 1'b0;
        checks++;
        if (obs_v !== exp_v) begin
            fails++; $display("FAIL random_run_model got %h want %h", obs_v, exp_v);
        end
        checks++;
        if ({ifc.pass_cnt, ifc.fail_cnt, ifc.error, ifc.busy, ifc.done} !== {16'd19, 16'd0, 3'b001}) begin
            fails++; $display("FAIL random_run_counts got pass=%0d fail=%0d err=%b busy=%b done=%b want 19/0/0/0/1",
                              ifc.pass_cnt, ifc.fail_cnt, ifc.error, ifc.busy, ifc.done);
        end
    endtask

    task automatic test_start_stop_ignored();
        ifc.stop = 1'b1; tick();
        checks++;
        if ({ifc.pass_cnt, ifc.done} !== {16'd19, 1'b1}) begin
            fails++; $display("FAIL stop_in_done got pass=%0d done=%b want 19 1", ifc.pass_cnt, ifc.done);
        end
        ifc.start = 1'b1; tick();
        checks++;
        if ({ifc.pass_cnt, ifc.busy, ifc.done} !== {16'd0, 2'b10}) begin
            fails++; $display("FAIL restart_clears got pass=%0d busy=%b done=%b want 0 1 0",
                              ifc.pass_cnt, ifc.busy, ifc.done);
        end
        for (int i = 0; i < 3; i++) begin
            ifc.enable = 1'b1; ifc.d = $urandom; tick();
        end
        ifc.start = 1'b1; ifc.d = $urandom; tick();
        checks++;
        if ({ifc.pass_cnt, ifc.busy} !== {16'd3, 1'b1}) begin
            fails++; $display("FAIL start_in_run got pass=%0d busy=%b want 3 1", ifc.pass_cnt, ifc.busy);
        end
        ifc.enable = 1'b0; ifc.stop = 1'b1; tick();
        checks++;
        if (obs_v !== exp_v) begin
            fails++; $display("FAIL start_stop_model got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_no_enable();
        do_reset();
        reg_q = '0; ifc.z = '0;
        ifc.start = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin
            ifc.enable = 1'b0; ifc.d = $urandom; tick();
        end
        ifc.stop = 1'b1; tick();
        checks++;
        if ({ifc.pass_cnt, ifc.fail_cnt, ifc.expect_value, ifc.done} !== {16'd0, 16'd0, 32'd0, 1'b1}) begin
            fails++; $display("FAIL no_enable got pass=%0d fail=%0d expect=%h done=%b want 0 0 0 1",
                              ifc.pass_cnt, ifc.fail_cnt, ifc.expect_value, ifc.done);
        end
    endtask

    task automatic test_corruption();
        logic [15:0] want_pass;
        logic [1:0]  want_bd;
        do_reset();
        ifc.start = 1'b1; tick();
        ifc.enable = 1'b1; ifc.d = 32'h0000_0005; tick();
        ifc.enable = 1'b0; ifc.z = 32'hDEAD_BEEF; tick();
        checks++;
        if ({ifc.fail_cnt, ifc.error} !== {16'd1, 1'b1}) begin
            fails++; $display("FAIL corrupt_edge got fail=%0d err=%b want 1 1", ifc.fail_cnt, ifc.error);
        end
        for (int i = 0; i < 4; i++) tick();
        want_pass = HALT ? 16'd0 : 16'd4;
        want_bd   = HALT ? 2'b01 : 2'b10;
        checks++;
        if ({ifc.pass_cnt, ifc.fail_cnt, ifc.error, ifc.busy, ifc.done, ifc.expect_value}
            !== {want_pass, 16'd1, 1'b1, want_bd, 32'h0000_0005}) begin
            fails++; $display("FAIL corrupt_after got pass=%0d fail=%0d err=%b busy=%b done=%b want %0d 1 1 %b",
                              ifc.pass_cnt, ifc.fail_cnt, ifc.error, ifc.busy, ifc.done, want_pass, want_bd);
        end
        ifc.stop = 1'b1; tick();
        checks++;
        if (obs_v !== exp_v) begin
            fails++; $display("FAIL corrupt_model got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ifc.start = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin
            ifc.enable = 1'b1; ifc.d = $urandom; tick();
        end
        checks++;
        if (ifc.pass_cnt !== 16'd5) begin
            fails++; $display("FAIL mid_run_pass got %0d want 5", ifc.pass_cnt);
        end
        reset = 1'b1; ifc.start = 1'b1; ifc.stop = 1'b1; tick();
        reset = 1'b0;
        checks++;
        if (obs_v !== 67'd0) begin
            fails++; $display("FAIL mid_run_reset got %h want %h", obs_v, 67'd0);
        end
        ifc.enable = 1'b0; ifc.start = 1'b1; tick();
        for (int k = 1; k <= 4; k++) begin
            ifc.enable = 1'b1; ifc.d = $urandom; ifc.stop = (k == 4); tick();
        end
        ifc.enable = 1'b0;
        checks++;
        if ({ifc.pass_cnt, ifc.done} !== {16'd3, 1'b1}) begin
            fails++; $display("FAIL rerun_pass got pass=%0d done=%b want 3 1", ifc.pass_cnt, ifc.done);
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            ifc.start  = ($urandom_range(0, 9) == 0);
            ifc.stop   = ($urandom_range(0, 14) == 0);
            ifc.enable = $urandom_range(0, 1);
            ifc.d      = $urandom_range(0, 3) == 0 ? 32'(i) : $urandom;
            if ($urandom_range(0, 7) == 0) ifc.z = $urandom;
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                fails++; $display("FAIL random_cycle%0d got %h want %h", i, obs_v, exp_v);
            end
        end
        reset = 1'b0; ifc.enable = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        ifc.start = 1'b1; tick();
        for (int i = 0; i < 65540; i++) begin
            ifc.enable = 1'b1; ifc.d = $urandom; tick();
        end
        ifc.enable = 1'b0;
        checks++;
        if ({ifc.pass_cnt, ifc.fail_cnt, ifc.busy} !== {16'hFFFF, 16'd0, 1'b1}) begin
            fails++; $display("FAIL pass_saturate got pass=%h fail=%0d busy=%b want ffff 0 1",
                              ifc.pass_cnt, ifc.fail_cnt, ifc.busy);
        end
        for (int i = 0; i < 3; i++) tick();
        ifc.stop = 1'b1; tick();
        checks++;
        if (obs_v !== exp_v) begin
            fails++; $display("FAIL saturate_model got %h want %h", obs_v, exp_v);
        end
    endtask

    initial begin
        reset = 1'b1;
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.enable = 1'b0; ifc.d = '0; ifc.z = '0;
        test_reset();
        test_random_run();
        test_start_stop_ignored();
        test_no_enable();
        test_corruption();
        test_mid_reset();
        test_random_traffic();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/reg_checker.md
REG_CHECKER -- requirements
Module: reg_checker

Interface
REQ-001 Parameter: SIZE, default 32, data width of the register under check.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a checking run.
REQ-005 stop  input  1  one-cycle pulse; ends a checking run.
REQ-006 enable  input  1  write enable driven to the register under check.
REQ-007 d  input  SIZE  data input driven to the register under check.
REQ-008 z  input  SIZE  output of the register under check.
REQ-009 expect  output  SIZE  golden model value.
REQ-010 pass_cnt  output  16  count of matching compares.
REQ-011 fail_cnt  output  16  count of mismatching compares.
REQ-012 error  output  1  sticky; set by any mismatch in the current run.
REQ-013 busy  output  1  high in RUN state.
REQ-014 done  output  1  high in DONE or FAIL state.

Function
REQ-015 States SHALL be IDLE, RUN, DONE, FAIL; the reset state SHALL be IDLE.
REQ-016 IDLE->RUN on start; start in DONE or FAIL SHALL also enter RUN; start in RUN SHALL be ignored.
REQ-017 RUN->DONE on stop; stop in IDLE, DONE or FAIL SHALL be ignored; stop SHALL win over a simultaneous compare only for the next state, and that edge's compare SHALL still be counted.
REQ-018 Entering RUN SHALL clear pass_cnt, fail_cnt, error and the internal model_valid flag at the same edge.
REQ-019 In RUN, at a posedge with enable=1, expect SHALL load d and model_valid SHALL set; enable=0 SHALL hold expect.
REQ-020 In RUN, at each posedge with model_valid=1, z SHALL be compared with the pre-edge value of expect; this gives zero latency relative to the register's own update.
REQ-021 A match SHALL increment pass_cnt; a mismatch SHALL increment fail_cnt and set error; both are visible one cycle after the compare edge.
REQ-022 Counters SHALL saturate at 16'hFFFF, with no wrap-around.
REQ-023 No compare SHALL occur while model_valid=0; the first enable edge after start SHALL only load the model.
REQ-024 expect, counters and error SHALL hold their values in IDLE, DONE and FAIL.
REQ-025 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE || state==FAIL), both registered-state decodes.

Reset
REQ-026 On reset=1 at posedge: state=IDLE, expect=0, pass_cnt=0, fail_cnt=0, error=0, model_valid=0, busy=0, done=0.
REQ-027 Reset SHALL override start, stop and enable in every state, including mid-run.
REQ-028 X on z during reset SHALL NOT affect any counter.

Configuration
REQ-029 Macro CHK_HALT_ON_FAIL_EN: when defined, the first mismatch in RUN SHALL count once, set error, and move the block to FAIL; later edges SHALL NOT compare.
REQ-030 Without CHK_HALT_ON_FAIL_EN, FAIL SHALL be unreachable and mismatches SHALL keep counting in RUN until stop.

Verification
REQ-031 Reset, then start, then 20 random d values with enable=1 every edge, with z driven by a correct register -> pass_cnt=19, fail_cnt=0, error=0 after stop, and done=1.
REQ-032 enable=0 for the whole run with z held at 0 -> no compares, pass_cnt=0, fail_cnt=0, expect=0.
REQ-033 Inject a z corruption (z=32'hDEADBEEF while expect=32'h00000005) on one edge, no macro -> fail_cnt=1, error=1, and the run continues with pass_cnt growing.
REQ-034 Same corruption with CHK_HALT_ON_FAIL_EN defined -> fail_cnt=1, state FAIL, done=1, busy=0, and counters frozen afterwards.
REQ-035 Assert reset mid-run after 5 passes -> all outputs 0 on the next cycle; a new start with 3 matches gives pass_cnt=3.
REQ-036 Force pass_cnt to 16'hFFFE, then run 4 matching edges -> pass_cnt=16'hFFFF held.
